// File: rtl/routed_input_port.sv
// routed_input_port: XY-routing router input port (header decode, next-hop rewrite, forwarding).
// Optional grant watchdog enabled by defining PORT_GRANT_TIMEOUT_EN.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   fifo_empty, flit_in   input FIFO status and head flit
//   read_fifo             pop the input FIFO
//   request_vector        one-hot request {S,N,W,E,L}
//   grant                 arbiter grant
//   destination_full_vector  downstream full flags, aligned with request_vector
//   flit_out, flit_valid  outgoing flit stream
//   packet_done           pulse on the last flit of a packet
//   err_timeout           sticky grant watchdog flag
module routed_input_port #(
  parameter int FLIT_W        = 4,
  parameter int ADDR_W        = 16,
  parameter int PKT_W         = 32,
  parameter int GRANT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [FLIT_W-1:0] flit_in,
  output logic              read_fifo,
  output logic [4:0]        request_vector,
  input  logic              grant,
  input  logic [4:0]        destination_full_vector,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  output logic              packet_done,
  output logic              err_timeout
);

  localparam int HF = ADDR_W / FLIT_W;
  localparam int PF = PKT_W / FLIT_W;
  localparam int H  = ADDR_W / 2;
  localparam int CW = $clog2(PF + 1);
  localparam int AW = ADDR_W - FLIT_W;

  localparam logic [CW-1:0] C1      = CW'(1);
  localparam logic [CW-1:0] HF_LAST = CW'(HF - 1);
  localparam logic [CW-1:0] PL_LAST = CW'(PF - HF - 1);
  localparam logic [H-1:0]  ONE     = H'(1);

  typedef enum logic [2:0] {
    IDLE, HEADER, ROUTE, SEND_HDR, SEND_PAYLOAD
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0] nxt_q, nxt_d;
  logic [4:0]        route_q, route_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              rd, fv, pd;
  logic [FLIT_W-1:0] fo;
  logic              dst_full;
  logic              pop;
  logic [ADDR_W-1:0] hdr;
  logic [H-1:0]      dx, dy;
  logic              dx_z, dy_z;
  logic [4:0]        rt_vec;
  logic [ADDR_W-1:0] rt_nxt;

  // Header as it will look once the current head flit is shifted in.
  assign hdr  = {flit_in, addr_q};
  assign dx   = hdr[H-1:0];
  assign dy   = hdr[ADDR_W-1:H];
  assign dx_z = (dx == '0);
  assign dy_z = (dy == '0);

  always_comb begin
    rt_vec = 5'b00001;
    rt_nxt = hdr;
    unique case (1'b1)
      !dx_z && !dx[H-1]: begin
        rt_vec = 5'b00010;
        rt_nxt = {dy, dx - ONE};
      end
      !dx_z && dx[H-1]: begin
        rt_vec = 5'b00100;
        rt_nxt = {dy, dx + ONE};
      end
      dx_z && !dy_z && !dy[H-1]: begin
        rt_vec = 5'b01000;
        rt_nxt = {dy - ONE, dx};
      end
      dx_z && !dy_z && dy[H-1]: begin
        rt_vec = 5'b10000;
        rt_nxt = {dy + ONE, dx};
      end
      default: begin
        rt_vec = 5'b00001;
        rt_nxt = hdr;
      end
    endcase
  end

  assign request_vector =
    (state_q == ROUTE || state_q == SEND_HDR ||
     state_q == SEND_PAYLOAD) ? route_q : 5'b0;
  assign dst_full = |(request_vector & destination_full_vector);

  // Popping is combinational, so hold it low while reset is asserted.
  assign read_fifo   = rd & reset;
  assign pop         = read_fifo;
  assign flit_valid  = fv;
  assign flit_out    = fo;
  assign packet_done = pd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (pop) state_d = HEADER;
      HEADER:
        if (pop && cnt_q == HF_LAST) state_d = ROUTE;
      ROUTE:
        if (grant && !dst_full) state_d = SEND_HDR;
      SEND_HDR:
        if (!dst_full && cnt_q == HF_LAST) state_d = SEND_PAYLOAD;
      SEND_PAYLOAD:
        if (pop && cnt_q == PL_LAST) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    rd = 1'b0;
    fv = 1'b0;
    fo = '0;
    pd = 1'b0;
    unique case (state_q)
      IDLE, HEADER:
        rd = !fifo_empty;
      SEND_HDR: begin
        fv = !dst_full;
        fo = fv ? nxt_q[FLIT_W-1:0] : '0;
      end
      SEND_PAYLOAD: begin
        rd = !fifo_empty && !dst_full;
        fv = rd;
        fo = rd ? flit_in : '0;
        pd = rd && (cnt_q == PL_LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    nxt_d   = nxt_q;
    route_d = route_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, HEADER:
        if (pop) begin
          addr_d = hdr[ADDR_W-1:FLIT_W];
          cnt_d  = cnt_q + C1;
          if (cnt_q == HF_LAST) begin
            route_d = rt_vec;
            nxt_d   = rt_nxt;
            cnt_d   = '0;
          end
        end
      SEND_HDR:
        if (!dst_full) begin
          nxt_d = nxt_q >> FLIT_W;
          cnt_d = (cnt_q == HF_LAST) ? '0 : cnt_q + C1;
        end
      SEND_PAYLOAD:
        if (pop) begin
          cnt_d = cnt_q + C1;
          if (cnt_q == PL_LAST) begin
            cnt_d   = '0;
            route_d = '0;
          end
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      nxt_q   <= '0;
      route_q <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      nxt_q   <= nxt_d;
      route_q <= route_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PORT_GRANT_TIMEOUT_EN
  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LIM = TW'(GRANT_TIMEOUT);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Counts consecutive ROUTE cycles that do not leave ROUTE; saturates.
  always_comb begin
    tmo_d = '0;
    err_d = err_q;
    if (state_q == ROUTE && state_d == ROUTE) begin
      tmo_d = (tmo_q == T_LIM) ? tmo_q : tmo_q + TW'(1);
      if (tmo_d == T_LIM) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/routed_input_port.md
ROUTED_INPUT_PORT -- requirements
Module: routed_input_port

Interface
REQ-001 The block SHALL have parameter FLIT_W, default 4, flit width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 16, header address width; SHALL be an even multiple of FLIT_W.
REQ-003 The block SHALL have parameter PKT_W, default 32, total packet width; SHALL be a multiple of FLIT_W and greater than ADDR_W.
REQ-004 The block SHALL have parameter GRANT_TIMEOUT, default 255, grant watchdog limit in cycles.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port fifo_empty, input, 1, input FIFO empty.
REQ-008 The block SHALL have port flit_in, input, FLIT_W, head of the input FIFO, valid in the same cycle as read_fifo.
REQ-009 The block SHALL have port read_fifo, output, 1, pop the input FIFO.
REQ-010 The block SHALL have port request_vector, output, 5, one-hot arbiter request: bit0 local, bit1 east, bit2 west, bit3 north, bit4 south.
REQ-011 The block SHALL have port grant, input, 1, arbiter grant for this port.
REQ-012 The block SHALL have port destination_full_vector, input, 5, full flags of the downstream ports, bit-aligned with request_vector.
REQ-013 The block SHALL have port flit_out, output, FLIT_W, outgoing flit.
REQ-014 The block SHALL have port flit_valid, output, 1, flit_out valid this cycle.
REQ-015 The block SHALL have port packet_done, output, 1, one-cycle pulse on the last flit of a packet.
REQ-016 The block SHALL have port err_timeout, output, 1, sticky grant-timeout flag.

Function
REQ-017 HF = ADDR_W/FLIT_W header flits; PF = PKT_W/FLIT_W total flits; header and payload SHALL arrive and depart LSB flit first.
REQ-018 The FSM SHALL have states IDLE, HEADER, ROUTE, SEND_HDR, SEND_PAYLOAD.
REQ-019 In IDLE and HEADER, read_fifo SHALL equal !fifo_empty; each popped flit SHALL shift into the address register at the MSB end; IDLE SHALL go to HEADER on the first pop.
REQ-020 After HF flits have been popped, the FSM SHALL go to ROUTE in the next cycle, and the routing result and next address SHALL be registered on that edge.
REQ-021 The address SHALL be split into dx = low ADDR_W/2 bits and dy = high ADDR_W/2 bits, both two's complement.
REQ-022 Routing SHALL be X-first: dx>0 east with dx-1; dx<0 west with dx+1; dx=0 and dy>0 north with dy-1; dx=0 and dy<0 south with dy+1; both zero local with the address unchanged.
REQ-023 request_vector SHALL be 0 in IDLE and HEADER, and SHALL hold the registered one-hot result in ROUTE, SEND_HDR and SEND_PAYLOAD.
REQ-024 destination_full SHALL be the destination_full_vector bit selected by request_vector, and 0 when request_vector is 0.
REQ-025 ROUTE SHALL go to SEND_HDR on the edge where grant=1 and destination_full=0; otherwise it SHALL hold with no FIFO pops.
REQ-026 In SEND_HDR, each cycle with destination_full=0 SHALL assert flit_valid with flit_out = next-address LSB flit, then shift the next-address register right by FLIT_W with zero fill; after HF flits the FSM SHALL go to SEND_PAYLOAD.
REQ-027 In SEND_PAYLOAD: read_fifo = !fifo_empty & !destination_full, flit_valid = read_fifo, and flit_out = flit_in.
REQ-028 On the (PF-HF)th payload flit, packet_done SHALL pulse and the FSM SHALL go to IDLE with request_vector cleared the next cycle.
REQ-029 destination_full=1 or an empty FIFO mid-packet SHALL stall: flit_valid=0, counters held, no flit lost or duplicated.
REQ-030 When flit_valid=0, flit_out SHALL be 0.
REQ-031 Loss of grant after ROUTE SHALL be ignored; the arbiter SHALL hold grant until packet_done.

Reset
REQ-032 While reset=0, the FSM SHALL be in IDLE and all registers, counters and outputs (request_vector, read_fifo, flit_out, flit_valid, packet_done, err_timeout) SHALL be 0.
REQ-033 Reset asserted mid-packet SHALL discard the partial packet; no recovery of flits already popped.

Configuration
REQ-034 With PORT_GRANT_TIMEOUT_EN defined, a counter SHALL count consecutive ROUTE cycles without a transition; on reaching GRANT_TIMEOUT it SHALL set err_timeout, which stays set until reset, with forwarding unaffected.
REQ-035 Without PORT_GRANT_TIMEOUT_EN, no counter SHALL exist and err_timeout SHALL be tied to 0.

Verification
REQ-036 At X=0,Y=0, FIFO holds header 16'h0002 then payload 16'hABCD, grant=1 -> request_vector=5'b00010; flit_out header flits 1,0,0,0 then payload D,C,B,A; one packet_done.
REQ-037 Header 16'h0300 (dx=0, dy=3) -> request_vector=5'b01000; regenerated header 16'h0200.
REQ-038 Header 16'h00FF (dx=-1) -> west 5'b00100, next address 16'h0000; a second packet with header 0 -> local 5'b00001.
REQ-039 destination_full_vector[1] toggles every 2 cycles and the FIFO runs empty for 3 cycles mid-payload -> output flit sequence identical to the unstalled case; read_fifo never asserted while full or empty.
REQ-040 Reset pulled low during SEND_PAYLOAD -> all outputs 0 immediately; next packet routes correctly.
REQ-041 With PORT_GRANT_TIMEOUT_EN defined and GRANT_TIMEOUT=8, grant=0 -> err_timeout rises after 8 ROUTE cycles and stays 1 after a later grant; without the macro it stays 0.
